// File: rtl/poly_memory_sequencer.sv
// Address and control sequencer for moving AMNS operands (A, B, M, M'0) out of BRAM
// and the result polynomial (RES) back into it, with a store queued behind a running load.
module poly_memory_sequencer #(
  parameter int WORD_WIDTH   = 17,
  parameter int N            = 5,
  parameter int S            = 4,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(4*N*S+N)+1,
  localparam int IDX_W       = $clog2(N*S)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic              store_start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              store_pending_o,
  output logic              BRAM_we_o,
  output logic [ADDR_W-1:0] BRAM_addr_o,
  output logic [1:0]        INPUT_reg_sel_o,
  output logic              INPUT_reg_en_o,
  output logic [IDX_W-1:0]  INPUT_word_idx_o,
  output logic              store_RES_reg_en_o,
  output logic              load_done_o,
  output logic              store_done_o
);

  localparam int NS = N*S;
  localparam logic [IDX_W-1:0]  IDX_LAST_NS = IDX_W'(NS-1);
  localparam logic [IDX_W-1:0]  IDX_LAST_N  = IDX_W'(N-1);
  localparam logic [ADDR_W-1:0] OFF_B       = ADDR_W'(NS);
  localparam logic [ADDR_W-1:0] OFF_M       = ADDR_W'(2*NS);
  localparam logic [ADDR_W-1:0] OFF_MP      = ADDR_W'(3*NS);
  localparam logic [ADDR_W-1:0] OFF_RES     = ADDR_W'(3*NS+N);
  localparam logic [2:0]        DRAIN_LAST  = 3'((READ_LATENCY > 0) ? READ_LATENCY-1 : 0);

  generate
    if (READ_LATENCY < 0 || READ_LATENCY > 4 || WORD_WIDTH < 1) begin : g_bad_params
      $error("poly_memory_sequencer: READ_LATENCY must be 0..4 and WORD_WIDTH positive");
    end
  endgenerate

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, LOAD_M, LOAD_MP, LOAD_DRAIN, LOAD_DONE, STORE_RES, STORE_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [2:0]        drain_reg, drain_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] store_base_reg, store_base_next;
  logic              pending_reg, pending_next;

  logic              rd_en;
  logic [1:0]        rd_sel;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] region_off;
  logic              addr_active;
  logic              write_en;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      drain_reg      <= '0;
      base_reg       <= '0;
      store_base_reg <= '0;
      pending_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      drain_reg      <= drain_next;
      base_reg       <= base_next;
      store_base_reg <= store_base_next;
      pending_reg    <= pending_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    drain_next      = drain_reg;
    base_next       = base_reg;
    store_base_next = store_base_reg;
    pending_next    = pending_reg;
    rd_en           = 1'b0;
    rd_sel          = 2'd0;
    rd_idx          = '0;
    region_off      = '0;
    addr_active     = 1'b0;
    write_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next   = STORE_RES;
          idx_next     = '0;
          base_next    = store_base_reg;
          pending_next = 1'b0;
        end else if (load_start_i) begin
          state_next = LOAD_A;
          idx_next   = '0;
          base_next  = base_addr_i;
          // A store arriving with the load waits behind it, using the same base.
          if (store_start_i) begin
            pending_next    = 1'b1;
            store_base_next = base_addr_i;
          end
        end else if (store_start_i) begin
          state_next = STORE_RES;
          idx_next   = '0;
          base_next  = base_addr_i;
        end
      end
      LOAD_A, LOAD_B, LOAD_M: begin
        rd_en       = 1'b1;
        rd_idx      = idx_reg;
        addr_active = 1'b1;
        case (state_reg)
          LOAD_A:  begin rd_sel = 2'd0; region_off = '0;    end
          LOAD_B:  begin rd_sel = 2'd1; region_off = OFF_B; end
          default: begin rd_sel = 2'd2; region_off = OFF_M; end
        endcase
        if (idx_reg == IDX_LAST_NS) begin
          idx_next = '0;
          case (state_reg)
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = LOAD_M;
            default: state_next = LOAD_MP;
          endcase
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      LOAD_MP: begin
        rd_en       = 1'b1;
        rd_sel      = 2'd3;
        rd_idx      = idx_reg;
        region_off  = OFF_MP;
        addr_active = 1'b1;
        if (idx_reg == IDX_LAST_N) begin
          idx_next   = '0;
          drain_next = '0;
          state_next = (READ_LATENCY == 0) ? LOAD_DONE : LOAD_DRAIN;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      LOAD_DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          state_next = LOAD_DONE;
          drain_next = '0;
        end else begin
          drain_next = drain_reg + 3'd1;
        end
      end
      LOAD_DONE: begin
        state_next = IDLE;
        if (pending_reg) begin
          state_next   = STORE_RES;
          idx_next     = '0;
          base_next    = store_base_reg;
          pending_next = 1'b0;
        end else if (store_start_i) begin
          state_next = STORE_RES;
          idx_next   = '0;
          base_next  = base_addr_i;
        end
      end
      STORE_RES: begin
        write_en    = 1'b1;
        region_off  = OFF_RES;
        addr_active = 1'b1;
        if (idx_reg == IDX_LAST_NS) begin
          idx_next   = '0;
          state_next = STORE_DONE;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      STORE_DONE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase

    // Only the first store request seen during a load is remembered.
    if ((state_reg == LOAD_A || state_reg == LOAD_B || state_reg == LOAD_M ||
         state_reg == LOAD_MP || state_reg == LOAD_DRAIN) && store_start_i && !pending_reg) begin
      pending_next    = 1'b1;
      store_base_next = base_addr_i;
    end
  end

  assign busy_o             = (state_reg != IDLE);
  assign store_pending_o    = pending_reg;
  assign BRAM_we_o          = write_en;
  assign store_RES_reg_en_o = write_en;
  assign BRAM_addr_o        = addr_active ? (base_reg + region_off + ADDR_W'(idx_reg)) : base_reg;
  assign load_done_o        = (state_reg == LOAD_DONE);
  assign store_done_o       = (state_reg == STORE_DONE);

  // Operand-register controls trail the read by the BRAM data pipeline depth.
  generate
    if (READ_LATENCY == 0) begin : g_no_pipe
      assign INPUT_reg_sel_o  = rd_sel;
      assign INPUT_reg_en_o   = rd_en;
      assign INPUT_word_idx_o = rd_idx;
    end else begin : g_pipe
      logic [READ_LATENCY-1:0][1:0]       sel_pipe_reg;
      logic [READ_LATENCY-1:0]            en_pipe_reg;
      logic [READ_LATENCY-1:0][IDX_W-1:0] idx_pipe_reg;

      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          sel_pipe_reg <= '0;
          en_pipe_reg  <= '0;
          idx_pipe_reg <= '0;
        end else begin
          sel_pipe_reg[0] <= rd_sel;
          en_pipe_reg[0]  <= rd_en;
          idx_pipe_reg[0] <= rd_idx;
          for (int i = 1; i < READ_LATENCY; i++) begin
            sel_pipe_reg[i] <= sel_pipe_reg[i-1];
            en_pipe_reg[i]  <= en_pipe_reg[i-1];
            idx_pipe_reg[i] <= idx_pipe_reg[i-1];
          end
        end
      end

      assign INPUT_reg_sel_o  = sel_pipe_reg[READ_LATENCY-1];
      assign INPUT_reg_en_o   = en_pipe_reg[READ_LATENCY-1];
      assign INPUT_word_idx_o = idx_pipe_reg[READ_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_poly_memory_sequencer.sv
// Randomized scoreboard bench for poly_memory_sequencer: timed expectations are queued
// from the region/latency rules and a negedge monitor pops them as outputs appear.
module tb_poly_memory_sequencer;
  localparam int N = 5, S = 4, RL = 2, NS = N*S, AW = 8, IW = 5;
  localparam int LOAD_READS = 3*NS + N;
  localparam int RES_OFF    = 3*NS + N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load_start, store_start;
  logic [AW-1:0] base;
  logic          busy, pending, we, en, res_en, load_done, store_done;
  logic [AW-1:0] addr;
  logic [1:0]    sel;
  logic [IW-1:0] idx;

  poly_memory_sequencer #(.WORD_WIDTH(17), .N(N), .S(S), .READ_LATENCY(RL)) dut (
    .clock_i(clk), .reset_i(rst), .load_start_i(load_start), .store_start_i(store_start),
    .base_addr_i(base), .busy_o(busy), .store_pending_o(pending), .BRAM_we_o(we),
    .BRAM_addr_o(addr), .INPUT_reg_sel_o(sel), .INPUT_reg_en_o(en),
    .INPUT_word_idx_o(idx), .store_RES_reg_en_o(res_en), .load_done_o(load_done),
    .store_done_o(store_done)
  );

  typedef struct { int cyc; int addr; } addr_t;
  typedef struct { int cyc; int sel; int idx; } en_t;
  typedef struct { int cyc; int kind; } ev_t;   // kind 0 = load done, 1 = store done

  addr_t rd_q[$], wr_q[$];
  en_t   en_q[$];
  ev_t   ev_q[$];
  int checks = 0, errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: each read j of a load lands at ea+j, its data RL cycles later.
  function automatic void push_load(input int ea, input int b);
    int j = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < ((r == 3) ? N : NS); i++) begin
        rd_q.push_back('{cyc: ea + j, addr: (b + r*NS + i) % 256});
        en_q.push_back('{cyc: ea + j + RL, sel: r, idx: i});
        j++;
      end
    end
    ev_q.push_back('{cyc: ea + LOAD_READS + RL, kind: 0});
  endfunction

  function automatic void push_store(input int first, input int b);
    for (int i = 0; i < NS; i++)
      wr_q.push_back('{cyc: first + i, addr: (b + RES_OFF + i) % 256});
    ev_q.push_back('{cyc: first + NS, kind: 1});
  endfunction

  addr_t m_a;
  en_t   m_e;
  ev_t   m_v;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        m_a = rd_q.pop_front();
        chk("read_addr", int'(addr), m_a.addr);
        chk("read_cycle", cyc, m_a.cyc);
      end
      if (en) begin
        if (en_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_reg_en got sel %0d idx %0d at cycle %0d, none expected", sel, idx, cyc);
        end else begin
          m_e = en_q.pop_front();
          chk("reg_en_cycle", cyc, m_e.cyc);
          chk("reg_sel", int'(sel), m_e.sel);
          chk("word_idx", int'(idx), m_e.idx);
        end
      end else if (en_q.size() > 0 && en_q[0].cyc <= cyc) begin
        m_e = en_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_reg_en got none expected sel %0d idx %0d at cycle %0d", m_e.sel, m_e.idx, m_e.cyc);
      end
      if (we || res_en) chk("res_en_vs_we", int'(res_en), int'(we));
      if (we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write got addr %0d at cycle %0d, none expected", addr, cyc);
        end else begin
          m_a = wr_q.pop_front();
          chk("write_cycle", cyc, m_a.cyc);
          chk("write_addr", int'(addr), m_a.addr);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        m_a = wr_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_write got none expected addr %0d at cycle %0d", m_a.addr, m_a.cyc);
      end
      if (load_done || store_done) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got load %0d store %0d at cycle %0d, none expected", load_done, store_done, cyc);
        end else begin
          m_v = ev_q.pop_front();
          chk("done_kind", {30'd0, store_done, load_done}, (m_v.kind == 0) ? 1 : 2);
          chk("done_cycle", cyc, m_v.cyc);
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        m_v = ev_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_done got none expected kind %0d at cycle %0d", m_v.kind, m_v.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit ld, input bit st, input logic [AW-1:0] b);
    load_start = ld; store_start = st; base = b;
    tick();
    load_start = 1'b0; store_start = 1'b0; base = AW'($urandom);
  endtask

  task automatic start_load(input logic [AW-1:0] b, input bit with_store, output int ea);
    load_start = 1'b1; store_start = with_store; base = b;
    tick();
    ea = cyc;
    load_start = 1'b0; store_start = 1'b0; base = AW'($urandom);
    push_load(ea, int'(b));
    if (with_store) push_store(ea + LOAD_READS + RL + 1, int'(b));
    chk("load_busy", int'(busy), 1);
    chk("load_first_addr", int'(addr), int'(b));
    chk("load_pending", int'(pending), int'(with_store));
  endtask

  task automatic start_store(input logic [AW-1:0] b, output int ea);
    store_start = 1'b1; base = b;
    tick();
    ea = cyc;
    store_start = 1'b0; base = AW'($urandom);
    push_store(ea, int'(b));
    chk("store_busy", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      tick();
      t++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout got busy 1 expected 0 after %0d cycles", t);
    end
    tick(); tick();
    chk("queues_drained", rd_q.size() + en_q.size() + wr_q.size() + ev_q.size(), 0);
  endtask

  function automatic int out_bits();
    return int'({busy, pending, we, addr, sel, en, idx, res_en, load_done, store_done});
  endfunction

  initial begin
    int ea, d, kind;
    logic [AW-1:0] b, sb;
    rst = 1'b1; load_start = 1'b0; store_start = 1'b0; base = '0;
    #2;
    chk("reset_outputs", out_bits(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    start_load(8'd0, 1'b0, ea);   wait_idle();
    start_store(8'd100, ea);      wait_idle();
    start_load(8'd0, 1'b1, ea);   wait_idle();
    start_load(8'd250, 1'b0, ea); wait_idle();

    // Reset in the 30th cycle of a load: outputs drop at once and the job is abandoned.
    start_load(AW'($urandom), 1'b0, ea);
    repeat (29) tick();
    rst = 1'b1;
    #1;
    chk("midload_reset_outputs", out_bits(), 0);
    rd_q.delete(); en_q.delete(); wr_q.delete(); ev_q.delete();
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_reset_busy", int'(busy), 0);
    start_load(8'd0, 1'b0, ea); wait_idle();

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 4);
      b = AW'($urandom);
      case (kind)
        0: begin start_load(b, 1'b0, ea); wait_idle(); end
        1: begin start_store(b, ea); wait_idle(); end
        2: begin start_load(b, 1'b1, ea); wait_idle(); end
        3: begin
          start_load(b, 1'b0, ea);
          d = $urandom_range(0, 60);
          repeat (d) tick();
          sb = AW'($urandom);
          pulse(1'b0, 1'b1, sb);
          push_store(ea + LOAD_READS + RL + 1, int'(sb));
          chk("midload_pending", int'(pending), 1);
          pulse(1'b1, 1'b1, sb ^ 8'h5A);
          wait_idle();
        end
        default: begin
          start_store(b, ea);
          repeat ($urandom_range(0, 15)) tick();
          pulse(1'b1, 1'b1, AW'($urandom));
          chk("store_ignore_pending", int'(pending), 0);
          wait_idle();
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
